// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the parametrised UART transmitter.
//   tx_state_t  - serialiser states IDLE/START/DATA/PARITY/STOP
//   PAR_*       - parity-mode encodings for the PARITY_MODE parameter
//   frame_bits  - serial bit periods per frame (start + data + parity + stop)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int frame_bits(input int data_bits, input int parity_mode,
                                    input int stop_bits);
    return 1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous show-ahead FIFO feeding the UART serialiser.
//   clk, rst        - clock, synchronous active-high reset (empties the FIFO)
//   push, push_data - write request and word; ignored when full
//   pop             - read request; ignored when empty
//   pop_data        - head word, valid whenever empty = 0
//   full, empty     - occupancy flags
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter, LSB-first framed serial output.
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   tx_data   - word to transmit (DATA_BITS wide)
//   tx_valid  - tx_data valid; hold until accepted
//   tx_ready  - block accepts a word this cycle
//   tx        - serial line, idle high
//   busy      - frame in progress (or words pending in the FIFO)
// Optional feature: define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in
// front of the serialiser, giving back-to-back frames with no idle gap.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  if (CLK_DIV < 2) begin : g_chk_div
    $error("uart_tx_param: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) begin : g_chk_par
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

  tx_state_t            state;
  tx_state_t            state_next;
  logic [BAUD_W-1:0]    baud_cnt;
  // Indexes data bits in DATA and counts stop bits in STOP.
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 baud_end;
  logic                 frame_end;
  logic                 load;
  logic [DATA_BITS-1:0] load_data;
  logic                 load_par;

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && baud_end && (bit_idx == STOP_LAST);

  // Parity is fixed at capture time because the shift register is consumed.
  assign load_par = (PARITY_MODE == PAR_ODD) ? ~(^load_data) : ^load_data;

`ifdef UART_TX_FIFO_EN
  logic                 fifo_push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;

  assign tx_ready  = ~fifo_full & ~rst;
  assign fifo_push = tx_valid & tx_ready;
  // Popping in the last stop cycle chains straight into the next START.
  assign load      = ~fifo_empty & ((state == IDLE) | frame_end);
  assign load_data = fifo_data;
  assign busy      = ((state != IDLE) | ~fifo_empty) & ~rst;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (tx_data),
    .pop       (load),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
`else
  assign tx_ready  = (state == IDLE) & ~rst;
  assign load      = tx_valid & tx_ready;
  assign load_data = tx_data;
  assign busy      = (state != IDLE) & ~rst;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = START;
      START:   if (baud_end) state_next = DATA;
      DATA:    if (baud_end && bit_idx == DATA_LAST)
                 state_next = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
      PARITY:  if (baud_end) state_next = STOP;
      STOP:    if (frame_end) state_next = load ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      PARITY:  tx = par_bit;
      default: tx = 1'b1;
    endcase
    // The line goes idle as soon as reset is seen, not one edge later.
    if (rst) tx = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else if (load) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= load_data;
      par_bit  <= load_par;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (baud_end) begin
      baud_cnt <= '0;
      case (state)
        DATA: begin
          shift   <= {1'b0, shift[DATA_BITS-1:1]};
          bit_idx <= (bit_idx == DATA_LAST) ? '0 : bit_idx + 1'b1;
        end
        STOP:    bit_idx <= (bit_idx == STOP_LAST) ? '0 : bit_idx + 1'b1;
        default: bit_idx <= bit_idx;
      endcase
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: self-checking bench for uart_tx_param.
// Four instances cover 8N1, 8E1, 8O1 and 7N2 framing; expected waveforms are
// built from the frame definition (bit list expanded by the baud divisor).
module tb_uart_tx_param;
  import uart_pkg::*;

`ifdef UART_TX_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld [4] = '{default: 1'b0};
  logic [8:0] dat [4] = '{default: 9'h0};
  logic       rdy [4];
  logic       txw [4];
  logic       bsy [4];

  int cdiv  [4] = '{4, 4, 4, 3};
  int dbits [4] = '{8, 8, 8, 7};
  int pmode [4] = '{0, 1, 2, 0};
  int sbits [4] = '{1, 1, 1, 2};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt [4] = '{default: 0};
  int acc_cyc [4] = '{default: 0};

  typedef struct {
    int         inst;
    logic [8:0] data;
    int         exp_len;
    int         exp_par;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n81 (
    .clk(clk), .rst(rst), .tx_data(dat[0][7:0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx(txw[0]), .busy(bsy[0]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e81 (
    .clk(clk), .rst(rst), .tx_data(dat[1][7:0]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx(txw[1]), .busy(bsy[1]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o81 (
    .clk(clk), .rst(rst), .tx_data(dat[2][7:0]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx(txw[2]), .busy(bsy[2]));
  uart_tx_param #(.CLK_DIV(3), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_n72 (
    .clk(clk), .rst(rst), .tx_data(dat[3][6:0]), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .tx(txw[3]), .busy(bsy[3]));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (!rst && vld[i] && rdy[i]) begin
        acc_cnt[i] <= acc_cnt[i] + 1;
        acc_cyc[i] <= cyc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int flen(input int i);
    return frame_bits(dbits[i], pmode[i], sbits[i]) * cdiv[i];
  endfunction

  // Idle-high waveform with one frame of word w starting at cycle index lat.
  function automatic logic [255:0] model_wave(input int i, input logic [8:0] w, input int lat);
    logic [255:0] wv;
    logic [15:0]  bits;
    int           n;
    int           ones;
    wv   = '1;
    bits = '1;
    n    = 0;
    ones = 0;
    bits[n] = 1'b0;
    n++;
    for (int b = 0; b < dbits[i]; b++) begin
      bits[n] = w[b];
      ones += int'(w[b]);
      n++;
    end
    if (pmode[i] != 0) begin
      bits[n] = (pmode[i] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      n++;
    end
    for (int s = 0; s < sbits[i]; s++) begin
      bits[n] = 1'b1;
      n++;
    end
    for (int c = 0; c < n * cdiv[i]; c++) wv[lat + c] = bits[c / cdiv[i]];
    return wv;
  endfunction

  // Offers w on instance i, then records tx once per cycle starting the cycle
  // after the accepting edge; len is the first index at which busy is low.
  task automatic send_capture(input int i, input logic [8:0] w,
                              output logic [255:0] wv, output int len, output bit ok);
    int t;
    wv  = '1;
    len = -1;
    ok  = 1'b0;
    @(negedge clk);
    dat[i] = w;
    vld[i] = 1'b1;
    t = 0;
    while (!rdy[i] && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[i]) begin
      vld[i] = 1'b0;
      chk($sformatf("accept_timeout_i%0d_w%0h", i, dat[i]), 256'(rdy[i]), 256'(1));
      return;
    end
    @(negedge clk);
    vld[i] = 1'b0;
    dat[i] = 9'($urandom);
    for (int c = 0; c < LAT + flen(i) + 3; c++) begin
      wv[c] = txw[i];
      if (len < 0 && !bsy[i]) len = c;
      @(negedge clk);
    end
    ok = 1'b1;
  endtask

  initial begin
    logic [255:0] wv;
    logic [255:0] exp_wv;
    logic [255:0] bw;
    int           len;
    bit           ok;
    int           f;
    int           t;
    int           base;
    int           a0;
    logic [8:0]   w;
    logic [8:0]   burst [5];

    tbl[0] = '{0, 9'h0A5, 40, -1};
    tbl[1] = '{1, 9'h007, 44,  1};
    tbl[2] = '{2, 9'h007, 44,  0};
    tbl[3] = '{3, 9'h055, 30, -1};
    tbl[4] = '{1, 9'h0FF, 44,  0};
    tbl[5] = '{2, 9'h000, 44,  1};
    tbl[6] = '{0, 9'h000, 40, -1};
    tbl[7] = '{3, 9'h07F, 30, -1};

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx_i%0d", i), 256'(txw[i]), 256'(1));
      chk($sformatf("rst_busy_i%0d", i), 256'(bsy[i]), 256'(0));
      chk($sformatf("rst_ready_i%0d", i), 256'(rdy[i]), 256'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("idle_ready_i%0d", i), 256'(rdy[i]), 256'(1));
      chk($sformatf("idle_tx_i%0d", i), 256'(txw[i]), 256'(1));
    end

    // Table-driven frames
    for (int k = 0; k < 8; k++) begin
      send_capture(tbl[k].inst, tbl[k].data, wv, len, ok);
      if (ok) begin
        chk($sformatf("tbl%0d_wave", k), wv, model_wave(tbl[k].inst, tbl[k].data, LAT));
        chk($sformatf("tbl%0d_len", k), 256'(len), 256'(tbl[k].exp_len + LAT));
        if (tbl[k].exp_par >= 0)
          chk($sformatf("tbl%0d_parity", k),
              256'(wv[LAT + (1 + dbits[tbl[k].inst]) * cdiv[tbl[k].inst] + 1]),
              256'(tbl[k].exp_par));
        chk($sformatf("tbl%0d_ready_after", k), 256'(rdy[tbl[k].inst]), 256'(1));
      end
    end

    // Randomised words against the model
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 6; r++) begin
        w = 9'($urandom_range(0, (1 << dbits[i]) - 1));
        send_capture(i, w, wv, len, ok);
        if (ok) begin
          chk($sformatf("rand_i%0d_w%0h_wave", i, w), wv, model_wave(i, w, LAT));
          chk($sformatf("rand_i%0d_w%0h_len", i, w), 256'(len), 256'(flen(i) + LAT));
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

`ifndef UART_TX_FIFO_EN
    // Backpressure: 0x81 held valid during a frame is taken only at IDLE
    f = flen(0);
    base = acc_cnt[0];
    @(negedge clk);
    dat[0] = 9'h05A;
    vld[0] = 1'b1;
    t = 0;
    while (!rdy[0] && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("bp_first_ready", 256'(rdy[0]), 256'(1));
    @(negedge clk);
    a0 = acc_cyc[0];
    dat[0] = 9'h081;
    wv = '1;
    for (int c = 0; c < 2 * f + 5; c++) begin
      wv[c] = txw[0];
      if (acc_cnt[0] == base + 2) vld[0] = 1'b0;
      @(negedge clk);
    end
    vld[0] = 1'b0;
    exp_wv = model_wave(0, 9'h05A, 0) & model_wave(0, 9'h081, f + 1);
    chk("bp_wave", wv, exp_wv);
    chk("bp_accepts", 256'(acc_cnt[0] - base), 256'(2));
    chk("bp_period", 256'(acc_cyc[0] - a0), 256'(f + 1));
`else
    // FIFO burst: five words, frames back to back
    f = flen(0);
    burst = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055};
    base = acc_cnt[0];
    wv = '1;
    bw = '0;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          dat[0] = burst[k];
          vld[0] = 1'b1;
          t = 0;
          while (!rdy[0] && t < 1000) begin
            @(negedge clk);
            t++;
          end
          @(negedge clk);
        end
        vld[0] = 1'b0;
      end
      begin
        @(negedge clk);
        for (int c = 0; c < 5 * f + 4; c++) begin
          wv[c] = txw[0];
          bw[c] = bsy[0];
          @(negedge clk);
        end
      end
    join
    exp_wv = '1;
    for (int k = 0; k < 5; k++) exp_wv = exp_wv & model_wave(0, burst[k], 1 + k * f);
    chk("fifo_wave", wv, exp_wv);
    chk("fifo_accepts", 256'(acc_cnt[0] - base), 256'(5));
    chk("fifo_busy_last", 256'(bw[5 * f]), 256'(1));
    chk("fifo_busy_drop", 256'(bw[5 * f + 1]), 256'(0));
`endif

    // Reset during data bit 3, then a clean frame
    @(negedge clk);
    dat[0] = 9'h0A5;
    vld[0] = 1'b1;
    t = 0;
    while (!rdy[0] && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("midrst_busy_before", 256'(bsy[0]), 256'(1));
    rst = 1'b1;
    #1;
    chk("midrst_tx_during", 256'(txw[0]), 256'(1));
    @(negedge clk);
    chk("midrst_tx_after", 256'(txw[0]), 256'(1));
    chk("midrst_busy_after", 256'(bsy[0]), 256'(0));
    chk("midrst_ready_in_rst", 256'(rdy[0]), 256'(0));
    rst = 1'b0;
    send_capture(0, 9'h03C, wv, len, ok);
    if (ok) begin
      chk("postrst_wave", wv, model_wave(0, 9'h03C, LAT));
      chk("postrst_len", 256'(len), 256'(40 + LAT));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
